dmem_responder: RTL and testbench

- Data-memory responder that services the dmem request port driven by the pipeline's memory stage.
- Holds a small line-organised storage array of 128-bit lines and accepts one read or write at a time.
- Returns the full addressed line on dmem_rdata, with a one-cycle dmem_resp pulse after a programmable latency.
- Used as the simulation and FPGA stand-in for the data cache/memory behind the memory stage.

---
 rtl/lc3b_types.sv | 15 +
 rtl/dmem_responder_if.sv | 34 +++
 rtl/dmem_line_merge.sv | 27 ++
 rtl/dmem_responder.sv | 131 +++++++++++++
 tb/tb_dmem_responder.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/lc3b_types.sv
// Shared types for the data-memory responder slice.
// Word, line and mask widths plus the responder FSM state encoding.
package lc3b_types;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_data;
  typedef logic [1:0]   lc3b_mem_wmask;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } dmem_resp_state_t;

endpackage

// File: rtl/dmem_responder_if.sv
// Dmem request/response bundle between the memory stage and its responder.
// The master issues requests; the slave returns the line and a resp pulse.
interface dmem_responder_if;
  import lc3b_types::*;

  logic          dmem_read;
  logic          dmem_write;
  lc3b_word      dmem_address;
  lc3b_word      dmem_wdata;
  lc3b_mem_wmask dmem_byte_enable;
  lc3b_data      dmem_rdata;
  logic          dmem_resp;

  modport master (
    output dmem_read,
    output dmem_write,
    output dmem_address,
    output dmem_wdata,
    output dmem_byte_enable,
    input  dmem_rdata,
    input  dmem_resp
  );

  modport slave (
    input  dmem_read,
    input  dmem_write,
    input  dmem_address,
    input  dmem_wdata,
    input  dmem_byte_enable,
    output dmem_rdata,
    output dmem_resp
  );

endinterface

// File: rtl/dmem_line_merge.sv
// Byte-masked insertion of one 16-bit word into a 128-bit line.
// Purely combinational; slot picks the word, byte_enable the bytes.
module dmem_line_merge
  import lc3b_types::*;
(
  input  lc3b_data      line,
  input  logic [2:0]    slot,
  input  lc3b_word      wdata,
  input  lc3b_mem_wmask byte_enable,
  output lc3b_data      merged
);

  logic [6:0] lo_bit;
  logic [6:0] hi_bit;

  assign lo_bit = {slot, 4'd0};
  assign hi_bit = {slot, 4'd8};

  always_comb begin
    merged = line;
    if (byte_enable[0])
      merged[lo_bit +: 8] = wdata[7:0];
    if (byte_enable[1])
      merged[hi_bit +: 8] = wdata[15:8];
  end

endmodule

// File: rtl/dmem_responder.sv
// Line-organised data memory answering one dmem request at a time.
// Full line returned with a one-cycle resp after LATENCY cycles.
module dmem_responder
  import lc3b_types::*;
#(
  parameter int LATENCY = 3,
  parameter int LINES   = 16
) (
  input logic             clk,
  input logic             reset,
  dmem_responder_if.slave dmem
);

  localparam int IDX_W = $clog2(LINES);
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  dmem_resp_state_t state_q;
  dmem_resp_state_t state_d;
  logic [3:0]       cnt_q;
  logic [3:0]       cnt_d;

  logic          write_q;
  lc3b_word      addr_q;
  lc3b_word      wdata_q;
  lc3b_mem_wmask be_q;

  lc3b_data mem [LINES];
  lc3b_data rdata_q;

  logic          accept;
  logic          enter_resp;
  logic          cur_write;
  lc3b_word      cur_addr;
  lc3b_word      cur_wdata;
  lc3b_mem_wmask cur_be;

  logic [IDX_W-1:0] idx;
  logic [2:0]       slot;
  lc3b_data         line_rd;
  lc3b_data         line_mg;
  logic             unused_addr;

  assign accept = (state_q == IDLE) &&
                  (dmem.dmem_read || dmem.dmem_write);

  // With LATENCY=1 RESP is entered on the accept edge, so use live inputs
  always_comb begin
    if (state_q == IDLE) begin
      cur_write = dmem.dmem_write;
      cur_addr  = dmem.dmem_address;
      cur_wdata = dmem.dmem_wdata;
      cur_be    = dmem.dmem_byte_enable;
    end else begin
      cur_write = write_q;
      cur_addr  = addr_q;
      cur_wdata = wdata_q;
      cur_be    = be_q;
    end
  end

  assign idx         = cur_addr[4 +: IDX_W];
  assign slot        = cur_addr[3:1];
  assign line_rd     = mem[idx];
  assign unused_addr = ^{cur_addr[0], cur_addr[15:4+IDX_W]};

  dmem_line_merge u_merge (
    .line        (line_rd),
    .slot        (slot),
    .wdata       (cur_wdata),
    .byte_enable (cur_be),
    .merged      (line_mg)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (LATENCY == 1) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1)
          state_d = RESP;
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign enter_resp = (state_d == RESP);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rdata_q <= '0;
      for (int i = 0; i < LINES; i++)
        mem[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        write_q <= dmem.dmem_write;
        addr_q  <= dmem.dmem_address;
        wdata_q <= dmem.dmem_wdata;
        be_q    <= dmem.dmem_byte_enable;
      end
      if (enter_resp) begin
        rdata_q <= cur_write ? line_mg : line_rd;
        if (cur_write)
          mem[idx] <= line_mg;
      end
    end
  end

  assign dmem.dmem_rdata = rdata_q;
  assign dmem.dmem_resp  = (state_q == RESP);

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: vector table plus protocol corners.
// Runs a LATENCY=3 instance and a LATENCY=1 instance.
module tb_dmem_responder;
  import lc3b_types::*;

  logic clk;
  logic reset;

  dmem_responder_if bus ();
  dmem_responder_if bus1 ();

  dmem_responder #(.LATENCY(3), .LINES(16)) dut (
    .clk   (clk),
    .reset (reset),
    .dmem  (bus.slave)
  );

  dmem_responder #(.LATENCY(1), .LINES(16)) dut1 (
    .clk   (clk),
    .reset (reset),
    .dmem  (bus1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic     rd;
    logic     wr;
    lc3b_word addr;
    lc3b_word wdata;
    logic [1:0] be;
    lc3b_data exp;
  } vec_t;

  vec_t vecs [11];
  int n_vec;
  int n_miss;

  task automatic chk(input string name, input lc3b_data act,
                     input lc3b_data exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input int sel, input logic rd, input logic wr,
                       input lc3b_word addr, input lc3b_word wdata,
                       input logic [1:0] be);
    if (sel == 1) begin
      bus1.dmem_read = rd;
      bus1.dmem_write = wr;
      bus1.dmem_address = addr;
      bus1.dmem_wdata = wdata;
      bus1.dmem_byte_enable = be;
    end else begin
      bus.dmem_read = rd;
      bus.dmem_write = wr;
      bus.dmem_address = addr;
      bus.dmem_wdata = wdata;
      bus.dmem_byte_enable = be;
    end
  endtask

  function automatic logic resp_of(input int sel);
    return (sel == 1) ? bus1.dmem_resp : bus.dmem_resp;
  endfunction

  function automatic lc3b_data rdata_of(input int sel);
    return (sel == 1) ? bus1.dmem_rdata : bus.dmem_rdata;
  endfunction

  // Issue one request, hold it until resp, then check the pulse drops.
  task automatic txn(input int sel, input logic rd, input logic wr,
                     input lc3b_word addr, input lc3b_word wdata,
                     input logic [1:0] be, output lc3b_data rdata,
                     output int lat);
    @(negedge clk);
    drive(sel, rd, wr, addr, wdata, be);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!resp_of(sel) && lat < 40);
    rdata = rdata_of(sel);
    drive(sel, 1'b0, 1'b0, addr, wdata, be);
    @(posedge clk);
    #1;
    chk("resp_pulse_width", 128'(resp_of(sel)), 128'(0));
  endtask

  lc3b_data rd_v;
  int       lat;
  int       gap;

  initial begin
    n_vec  = 0;
    n_miss = 0;
    reset  = 1'b1;
    drive(0, 1'b0, 1'b0, 16'h0, 16'h0, 2'b00);
    drive(1, 1'b0, 1'b0, 16'h0, 16'h0, 2'b00);

    vecs[0]  = '{1'b1, 1'b0, 16'h0000, 16'h0000, 2'b00, 128'h0};
    vecs[1]  = '{1'b0, 1'b1, 16'h0012, 16'hBEEF, 2'b11,
                 {96'h0, 16'hBEEF, 16'h0}};
    vecs[2]  = '{1'b1, 1'b0, 16'h0010, 16'h0000, 2'b00,
                 {96'h0, 16'hBEEF, 16'h0}};
    vecs[3]  = '{1'b0, 1'b1, 16'h0012, 16'h12AB, 2'b01,
                 {96'h0, 16'hBEAB, 16'h0}};
    vecs[4]  = '{1'b0, 1'b1, 16'h0013, 16'hCD00, 2'b10,
                 {96'h0, 16'hCDAB, 16'h0}};
    vecs[5]  = '{1'b1, 1'b0, 16'h0010, 16'h0000, 2'b00,
                 {96'h0, 16'hCDAB, 16'h0}};
    vecs[6]  = '{1'b0, 1'b1, 16'h0012, 16'hFFFF, 2'b00,
                 {96'h0, 16'hCDAB, 16'h0}};
    vecs[7]  = '{1'b0, 1'b1, 16'h0100, 16'h5A5A, 2'b11,
                 {112'h0, 16'h5A5A}};
    vecs[8]  = '{1'b1, 1'b0, 16'h0000, 16'h0000, 2'b00,
                 {112'h0, 16'h5A5A}};
    vecs[9]  = '{1'b1, 1'b1, 16'h003E, 16'h1234, 2'b11,
                 {16'h1234, 112'h0}};
    vecs[10] = '{1'b1, 1'b0, 16'h0030, 16'h0000, 2'b00,
                 {16'h1234, 112'h0}};

    repeat (3) @(posedge clk);
    #1;
    chk("reset_resp", 128'(bus.dmem_resp), 128'(0));
    chk("reset_rdata", bus.dmem_rdata, 128'h0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 11; i++) begin
      txn(0, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata,
          vecs[i].be, rd_v, lat);
      chk($sformatf("vec%0d_rdata", i), rd_v, vecs[i].exp);
      chk($sformatf("vec%0d_latency", i), 128'(lat), 128'(3));
    end

    // Held read: back-to-back responses LATENCY+1 apart
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 16'h0010, 16'h0, 2'b00);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!bus.dmem_resp && lat < 40);
    chk("held_first_latency", 128'(lat), 128'(3));
    gap = 0;
    do begin
      @(posedge clk);
      #1;
      gap++;
    end while (!bus.dmem_resp && gap < 40);
    chk("held_resp_gap", 128'(gap), 128'(4));
    chk("held_rdata", bus.dmem_rdata, {96'h0, 16'hCDAB, 16'h0});
    drive(0, 1'b0, 1'b0, 16'h0, 16'h0, 2'b00);
    @(posedge clk);
    #1;
    chk("held_drop_resp", 128'(bus.dmem_resp), 128'(0));

    // Address change while waiting must not retarget the write
    @(negedge clk);
    drive(0, 1'b0, 1'b1, 16'h0040, 16'h7777, 2'b11);
    @(posedge clk);
    #1;
    drive(0, 1'b0, 1'b1, 16'h0050, 16'h1111, 2'b11);
    lat = 1;
    while (!bus.dmem_resp && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("addrchg_latency", 128'(lat), 128'(3));
    chk("addrchg_rdata", bus.dmem_rdata, {112'h0, 16'h7777});
    drive(0, 1'b0, 1'b0, 16'h0, 16'h0, 2'b00);
    @(posedge clk);
    txn(0, 1'b1, 1'b0, 16'h0050, 16'h0, 2'b00, rd_v, lat);
    chk("addrchg_other_line", rd_v, 128'h0);
    txn(0, 1'b1, 1'b0, 16'h0040, 16'h0, 2'b00, rd_v, lat);
    chk("addrchg_target_line", rd_v, {112'h0, 16'h7777});

    // LATENCY=1 instance
    txn(1, 1'b0, 1'b1, 16'h0002, 16'hA5A5, 2'b11, rd_v, lat);
    chk("lat1_write_latency", 128'(lat), 128'(1));
    chk("lat1_write_rdata", rd_v, {96'h0, 16'hA5A5, 16'h0});
    txn(1, 1'b1, 1'b0, 16'h0000, 16'h0, 2'b00, rd_v, lat);
    chk("lat1_read_latency", 128'(lat), 128'(1));
    chk("lat1_read_rdata", rd_v, {96'h0, 16'hA5A5, 16'h0});

    // Reset during WAIT of a write aborts it with no resp
    @(negedge clk);
    drive(0, 1'b0, 1'b1, 16'h0020, 16'h9999, 2'b11);
    @(posedge clk);
    #1;
    drive(0, 1'b0, 1'b0, 16'h0, 16'h0, 2'b00);
    chk("abort_wait_resp", 128'(bus.dmem_resp), 128'(0));
    #2;
    reset = 1'b1;
    #1;
    chk("abort_reset_resp", 128'(bus.dmem_resp), 128'(0));
    chk("abort_reset_rdata", bus.dmem_rdata, 128'h0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("abort_quiet%0d", i), 128'(bus.dmem_resp), 128'(0));
    end
    txn(0, 1'b1, 1'b0, 16'h0020, 16'h0, 2'b00, rd_v, lat);
    chk("abort_readback", rd_v, 128'h0);
    chk("abort_read_latency", 128'(lat), 128'(3));
    txn(0, 1'b1, 1'b0, 16'h0000, 16'h0, 2'b00, rd_v, lat);
    chk("reset_cleared_line0", rd_v, 128'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
